// File: rtl/xor_swap_engine.sv
// xor_swap_engine: registered operand exchange done in place with three XOR steps.
// A pair enters on in_valid/in_ready and the swapped pair leaves on out_valid/out_ready.
module xor_swap_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy,
    output logic [CNT_W-1:0] swap_count
);

    typedef enum logic [2:0] {
        IDLE,
        X1,
        X2,
        X3,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no branch can infer a latch.
        state_d = state_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    reg_a_d = in_a;
                    reg_b_d = in_b;
                    state_d = X1;
                end
            end
            X1: begin
                reg_a_d = reg_a_q ^ reg_b_q;
                state_d = X2;
            end
            X2: begin
                reg_b_d = reg_b_q ^ reg_a_q;
                state_d = X3;
            end
            X3: begin
                reg_a_d = reg_a_q ^ reg_b_q;
                state_d = DONE;
            end
            DONE: begin
                // The consume edge always returns to IDLE; no accept in the same cycle.
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_a_q <= '0;
            reg_b_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            count_q <= count_d;
        end
    end

    // Outputs are pure register decodes; data shows intermediate values until DONE.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_a      = reg_a_q;
    assign out_b      = reg_b_q;
    assign swap_count = count_q;

endmodule

// File: tb/tb_xor_swap_engine.sv
// Self-checking bench for xor_swap_engine: directed corner cases plus randomized pairs
// checked against a swap-and-count reference model.
module tb_xor_swap_engine;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;

    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_a, out_b;
    logic [15:0]  swap_count;

    logic         in_ready2, out_valid2, busy2;
    logic [W-1:0] out_a2, out_b2;
    logic [1:0]   swap_count2;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;   // pairs delivered since the last reset

    xor_swap_engine #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .busy(busy), .swap_count(swap_count)
    );

    // Narrow-counter instance shares all stimulus; only its counter is checked.
    xor_swap_engine #(.WIDTH(W), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid2), .out_ready(out_ready), .out_a(out_a2), .out_b(out_b2),
        .busy(busy2), .swap_count(swap_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one pair and waits (bounded) for its result; returns what was seen.
    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit noise, input bit consume,
                             output logic [W-1:0] oa, output logic [W-1:0] ob,
                             output int lat, output int bad);
        int guard;
        guard = 0;
        bad   = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = consume;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) bad++;
            in_a = W'($urandom);
            in_b = W'($urandom);
            if (noise) in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready || !busy) bad++;
        oa = out_a;
        ob = out_b;
        if (consume) begin
            @(posedge clk); #1;
            exp_count++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (out_a !== 8'h00 || out_b !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h/%h expected 00/00", out_a, out_b); end
        vectors++; if (swap_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", swap_count); end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [W-1:0] oa, ob;
        int lat, bad;
        send_pair(8'hA5, 8'h3C, 1'b0, 1'b1, oa, ob, lat, bad);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        vectors++; if (oa !== 8'h3C || ob !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h/%h expected 3c/a5", oa, ob); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL basic_ready_busy: got %0d bad cycles expected 0", bad); end
        vectors++; if (swap_count !== 16'd1) begin miscompares++; $display("FAIL basic_count: got %0d expected 1", swap_count); end
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_return_idle: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_corners();
        logic [W-1:0] av [3] = '{8'h77, 8'h00, 8'hFF};
        logic [W-1:0] bv [3] = '{8'h77, 8'hFF, 8'h00};
        logic [W-1:0] oa, ob;
        int lat, bad;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send_pair(av[i], bv[i], 1'b0, 1'b1, oa, ob, lat, bad);
            vectors++; if (oa !== bv[i] || ob !== av[i]) begin miscompares++; $display("FAIL corner_data[%0d]: got %h/%h expected %h/%h", i, oa, ob, bv[i], av[i]); end
            vectors++; if (bad !== 0 || lat !== 4) begin miscompares++; $display("FAIL corner_timing[%0d]: got bad=%0d lat=%0d expected 0/4", i, bad, lat); end
        end
        vectors++; if (swap_count !== 16'd3) begin miscompares++; $display("FAIL corner_count: got %0d expected 3", swap_count); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, oa, ob;
        int lat, bad;
        a = W'($urandom);
        b = W'($urandom);
        send_pair(a, b, 1'b0, 1'b0, oa, ob, lat, bad);
        vectors++; if (oa !== b || ob !== a) begin miscompares++; $display("FAIL bp_data: got %h/%h expected %h/%h", oa, ob, b, a); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_a !== b || out_b !== a || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h/%h ready=%b expected 1 %h/%h 0", i, out_valid, out_a, out_b, in_ready, b, a);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        vectors++; if (swap_count !== 16'(exp_count)) begin miscompares++; $display("FAIL bp_count: got %0d expected %0d", swap_count, exp_count); end
    endtask

    task automatic test_ignore_busy();
        logic [W-1:0] a, b, oa, ob;
        int lat, bad;
        a = W'($urandom);
        b = W'($urandom);
        send_pair(a, b, 1'b1, 1'b0, oa, ob, lat, bad);
        vectors++; if (oa !== b || ob !== a || lat !== 4) begin miscompares++; $display("FAIL busy_noise_data: got %h/%h lat=%0d expected %h/%h lat=4", oa, ob, lat, b, a); end
        in_valid  = 1'b1;
        in_a      = ~a;
        in_b      = ~b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL no_accept_on_consume: got busy=%b ready=%b expected 0/1", busy, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL accept_after_idle: got busy=%b expected 1", busy); end
        repeat (4) begin @(posedge clk); #1; end
        exp_count++;
        vectors++; if (out_valid !== 1'b0 || out_a !== 8'(~b) || out_b !== 8'(~a)) begin miscompares++; $display("FAIL second_pair: got valid=%b %h/%h expected 0 %h/%h", out_valid, out_a, out_b, 8'(~b), 8'(~a)); end
        vectors++; if (swap_count !== 16'(exp_count)) begin miscompares++; $display("FAIL busy_count: got %0d expected %0d", swap_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b, oa, ob;
        int lat, bad;
        in_valid  = 1'b1;
        in_a      = 8'h5A;
        in_b      = 8'hC3;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_ctrl: got ready=%b valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
        vectors++; if (out_a !== 8'h00 || out_b !== 8'h00) begin miscompares++; $display("FAIL midreset_regs: got %h/%h expected 00/00", out_a, out_b); end
        vectors++; if (swap_count !== 16'd0) begin miscompares++; $display("FAIL midreset_count: got %0d expected 0", swap_count); end
        @(negedge clk);
        rst_n = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        send_pair(a, b, 1'b0, 1'b1, oa, ob, lat, bad);
        vectors++; if (oa !== b || ob !== a || lat !== 4) begin miscompares++; $display("FAIL postreset_pair: got %h/%h lat=%0d expected %h/%h lat=4", oa, ob, lat, b, a); end
        vectors++; if (swap_count !== 16'd1) begin miscompares++; $display("FAIL postreset_count: got %0d expected 1", swap_count); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, oa, ob;
        int lat, bad, stall;
        for (int i = 0; i < 24; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            stall = $urandom_range(0, 3);
            send_pair(a, b, 1'($urandom), stall == 0, oa, ob, lat, bad);
            if (stall != 0) begin
                repeat (stall) begin @(posedge clk); #1; end
                out_ready = 1'b1;
                @(posedge clk); #1;
                exp_count++;
            end
            vectors++;
            if (oa !== b || ob !== a || lat !== 4 || bad !== 0) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h/%h lat=%0d bad=%0d expected %h/%h lat=4 bad=0", i, oa, ob, lat, bad, b, a);
            end
        end
        vectors++; if (swap_count !== 16'(exp_count)) begin miscompares++; $display("FAIL random_count: got %0d expected %0d", swap_count, exp_count); end
    endtask

    task automatic test_wrap();
        logic [1:0]   wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [W-1:0] oa, ob;
        int lat, bad;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            send_pair(W'($urandom), W'($urandom), 1'b0, 1'b1, oa, ob, lat, bad);
            vectors++; if (swap_count2 !== wrap_exp[k]) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, swap_count2, wrap_exp[k]); end
        end
        vectors++; if (swap_count !== 16'd5) begin miscompares++; $display("FAIL wide_count: got %0d expected 5", swap_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
